// File: rtl/capuccino_pkg.sv
// capuccino_pkg: shared op codes and default width for the capuccino ALU stage
package capuccino_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SADD = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_AVG  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;
endpackage

// File: rtl/capuccino_alu.sv
// capuccino_alu: combinational unsigned ALU producing result and carry/borrow/saturation flag
module capuccino_alu
  import capuccino_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  logic [WIDTH:0] s;
  logic [WIDTH:0] d;
  assign s = {1'b0, a} + {1'b0, b};
  assign d = {1'b0, a} - {1'b0, b};
  // Select result and flag; the extra top bit of s/d carries the carry, saturation or borrow
  always_comb begin
    result = s[WIDTH-1:0];
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = s[WIDTH-1:0]; carry = s[WIDTH]; end
      OP_SUB:  begin result = d[WIDTH-1:0]; carry = d[WIDTH]; end
      OP_SADD: begin result = s[WIDTH] ? '1 : s[WIDTH-1:0]; carry = s[WIDTH]; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_AVG:  begin result = s[WIDTH:1]; carry = s[0]; end
      OP_PASS: result = a;
      default: result = s[WIDTH-1:0];
    endcase
  end
endmodule

// File: rtl/capuccino.sv
// capuccino: single-cycle registered ALU stage with valid-in/valid-out and zero flag
module capuccino
  import capuccino_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lala,
  input  logic [WIDTH-1:0] planchuela,
  output logic [WIDTH-1:0] bebida,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  capuccino_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (lala),
    .b      (planchuela),
    .result (alu_result),
    .carry  (alu_carry)
  );
  // Capture a result only on accepted inputs; outputs hold otherwise, valid pulses per accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bebida    <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bebida <= alu_result;
        carry  <= alu_carry;
        zero   <= alu_result == '0;
      end
    end
  end
endmodule

// File: tb/tb_capuccino.sv
// tb_capuccino: scoreboard bench for the capuccino ALU stage with directed vectors
module tb_capuccino;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] lala = 8'd0;
  logic [7:0] planchuela = 8'd0;
  logic [7:0] bebida;
  logic       out_valid;
  logic       carry;
  logic       zero;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  capuccino dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .op         (op),
    .lala       (lala),
    .planchuela (planchuela),
    .bebida     (bebida),
    .out_valid  (out_valid),
    .carry      (carry),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic c);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op = o;
    lala = a;
    planchuela = b;
    sb.push_back({r, c, r == 8'd0});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got bebida=%0d carry=%0b zero=%0b with nothing expected", bebida, carry, zero);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({bebida, carry, zero} !== e) begin
          errors++;
          $display("FAIL result: got bebida=%0d carry=%0b zero=%0b expected bebida=%0d carry=%0b zero=%0b",
                   bebida, carry, zero, e[9:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #2;
    check("reset_state", {bebida, carry, zero}, 10'd0);
    check("reset_valid", {9'd0, out_valid}, 10'd0);
    #10;
    rst = 1'b0;
    send(3'd0, 8'd17, 8'd165, 8'd182, 1'b0);
    send(3'd0, 8'd17, 8'd99, 8'd116, 1'b0);
    send(3'd0, 8'd200, 8'd100, 8'd44, 1'b1);
    send(3'd2, 8'd200, 8'd100, 8'd255, 1'b1);
    send(3'd2, 8'd100, 8'd100, 8'd200, 1'b0);
    send(3'd1, 8'd17, 8'd99, 8'd174, 1'b1);
    send(3'd1, 8'd99, 8'd99, 8'd0, 1'b0);
    send(3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0);
    send(3'd4, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    send(3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0);
    send(3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0);
    send(3'd6, 8'd17, 8'd165, 8'd91, 1'b0);
    send(3'd6, 8'd255, 8'd254, 8'd254, 1'b1);
    send(3'd0, 8'd255, 8'd1, 8'd0, 1'b1);
    send(3'd1, 8'd0, 8'd1, 8'd255, 1'b1);
    send(3'd7, 8'd0, 8'd77, 8'd0, 1'b0);
    send(3'd2, 8'd255, 8'd0, 8'd255, 1'b0);
    send(3'd0, 8'd17, 8'd165, 8'd182, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lala = 8'($urandom);
      planchuela = 8'($urandom);
      op = 3'($urandom);
      #2;
      if (i > 0) begin
        check("hold_valid", {9'd0, out_valid}, 10'd0);
        check("hold_data", {bebida, carry, zero}, {8'd182, 1'b0, 1'b0});
      end
    end
    send(3'd5, 8'h0F, 8'hFF, 8'hF0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    check("pre_reset_valid", {9'd0, out_valid}, 10'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_reset_data", {bebida, carry, zero}, 10'd0);
    check("async_reset_valid", {9'd0, out_valid}, 10'd0);
    #3;
    rst = 1'b0;
    idle();
    #2;
    check("post_reset_idle", {9'd0, out_valid}, 10'd0);
    send(3'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    #3;
    check("latency_before_edge", {9'd0, out_valid}, 10'd0);
    idle();
    idle();
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results still pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
